// File: rtl/if_fetch_buffer_pkg.sv
// Shared constants and state encodings for the instruction fetch buffer.
// Contents:
//   RstEnable, ChipEnable, BblEnable/BblDisable, Branch - control-line levels
//   InstAddrBus, InstBus                                - default bus widths
//   fetch_state_e                                       - fetch FSM encoding
package if_fetch_buffer_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic ChipEnable  = 1'b1;
    localparam logic BblEnable   = 1'b1;
    localparam logic BblDisable  = 1'b0;
    localparam logic Branch      = 1'b1;
    localparam int   InstAddrBus = 32;
    localparam int   InstBus     = 32;

    typedef enum logic [1:0] {
        FetchIdle    = 2'b00,
        FetchReq     = 2'b01,
        FetchDiscard = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_buffer_if.sv
// Bus bundle between the fetch buffer, instruction memory and decode.
// Signals:
//   imem_req_o / imem_addr_o   - read request and address (fetch -> memory)
//   imem_ack_i / imem_rdata_i  - read completion and data (memory -> fetch)
//   id_valid_o / id_pc_o / id_inst_o - head entry offered to decode
//   id_ready_i                 - decode accepts the head entry
// Modports: master = fetch buffer side, slave = memory/decode side.
interface if_fetch_buffer_if #(
    parameter int AW = if_fetch_buffer_pkg::InstAddrBus,
    parameter int DW = if_fetch_buffer_pkg::InstBus
);

    logic          imem_req_o;
    logic [AW-1:0] imem_addr_o;
    logic          imem_ack_i;
    logic [DW-1:0] imem_rdata_i;
    logic          id_valid_o;
    logic [AW-1:0] id_pc_o;
    logic [DW-1:0] id_inst_o;
    logic          id_ready_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_rdata_i,
        output id_valid_o,
        output id_pc_o,
        output id_inst_o,
        input  id_ready_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_rdata_i,
        input  id_valid_o,
        input  id_pc_o,
        input  id_inst_o,
        output id_ready_i
    );

endinterface

// File: rtl/if_fetch_buffer_fetch_fifo.sv
// Synchronous FIFO with flush holding {pc, inst} pairs.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   push, din  - write an entry
//   pop        - drop the head entry (ignored when empty)
//   flush      - empty the FIFO; wins over push and pop
//   full, empty, count - occupancy
//   head       - registered storage at the read pointer
module if_fetch_buffer_fetch_fifo
    import if_fetch_buffer_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               din,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [W-1:0]               head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          pop_s;

    assign pop_s = pop & ~empty;

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            if (push && !pop_s) begin
                count_r <= count_r + CW'(1);
            end else if (!push && pop_s) begin
                count_r <= count_r - CW'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == CW'(0));
    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/if_fetch_buffer.sv
// Fetch stage between the PC register and decode. Issues one instruction
// read at a time, buffers {pc, inst} results and stalls the PC register
// while a read is outstanding or the buffer is full. A branch flushes the
// buffer and drops any in-flight read.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   pc_i, ce_i      - current PC and its valid flag
//   branch_flag_i   - redirect taken this cycle
//   bbl_o           - stall to the PC register (combinational)
//   bus             - memory request/response and decode handshake
module if_fetch_buffer
    import if_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = InstAddrBus,
    parameter int DW    = InstBus
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        pc_i,
    input  logic                 ce_i,
    input  logic                 branch_flag_i,
    output logic                 bbl_o,
    if_fetch_buffer_if.master    bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e     state_r;
    fetch_state_e     state_nxt_s;
    logic [AW-1:0]    addr_r;
    logic             req_r;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic             flush_s;
    logic             full_s;
    logic             empty_s;
    logic [CW-1:0]    count_s;
    logic [AW+DW-1:0] head_s;
    logic             bbl_s;

    // A stale pc_i during a branch cycle must never be fetched.
    assign accept_s = (state_r == FetchIdle) && (ce_i == ChipEnable) &&
                      (branch_flag_i != Branch) && (count_s < CW'(DEPTH));
    // Data is kept only when the read completes in REQ without a redirect.
    assign push_s   = (state_r == FetchReq) && bus.imem_ack_i && (branch_flag_i != Branch);
    assign pop_s    = ~empty_s & bus.id_ready_i;
    assign flush_s  = (branch_flag_i == Branch);

    if_fetch_buffer_fetch_fifo #(
        .W     (AW + DW),
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .din   ({addr_r, bus.imem_rdata_i}),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s),
        .head  (head_s)
    );

    // Next-state logic of the fetch FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            FetchIdle: begin
                if (accept_s) begin
                    state_nxt_s = FetchReq;
                end else begin
                    state_nxt_s = FetchIdle;
                end
            end
            FetchReq: begin
                if (bus.imem_ack_i) begin
                    state_nxt_s = FetchIdle;
                end else if (branch_flag_i == Branch) begin
                    state_nxt_s = FetchDiscard;
                end else begin
                    state_nxt_s = FetchReq;
                end
            end
            FetchDiscard: begin
                if (bus.imem_ack_i) begin
                    state_nxt_s = FetchIdle;
                end else begin
                    state_nxt_s = FetchDiscard;
                end
            end
            default: begin
                state_nxt_s = FetchIdle;
            end
        endcase
    end

    // Stall: never while branching so the PC register can always take the target.
    always_comb begin
        bbl_s = BblDisable;
        if (branch_flag_i == Branch) begin
            bbl_s = BblDisable;
        end else if ((state_r != FetchIdle) || full_s) begin
            bbl_s = BblEnable;
        end else begin
            bbl_s = BblDisable;
        end
    end

    // FSM state, request flag and held read address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state_r <= FetchIdle;
            req_r   <= 1'b0;
            addr_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            req_r   <= (state_nxt_s != FetchIdle);
            if (accept_s) begin
                addr_r <= pc_i;
            end else begin
                addr_r <= addr_r;
            end
        end
    end

    assign bbl_o           = bbl_s;
    assign bus.imem_req_o  = req_r;
    assign bus.imem_addr_o = addr_r;
    assign bus.id_valid_o  = ~empty_s;
    assign bus.id_pc_o     = head_s[AW+DW-1:DW];
    assign bus.id_inst_o   = head_s[DW-1:0];

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer. Stimulus tasks push hand-computed
// {pc, inst} entries into a queue; a monitor pops and compares each time
// decode takes an entry. Inputs change on the falling edge.
module tb_if_fetch_buffer;
    import if_fetch_buffer_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] inst;
    } entry_t;

    logic          clk;
    logic          rst;
    logic [AW-1:0] pc_i;
    logic          ce_i;
    logic          branch_flag_i;
    logic          bbl_o;

    if_fetch_buffer_if #(.AW(AW), .DW(DW)) bus ();

    if_fetch_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .ce_i          (ce_i),
        .branch_flag_i (branch_flag_i),
        .bbl_o         (bbl_o),
        .bus           (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        ce_n, br_n, rdy_n, stray_ack, ovr_en;
    logic [31:0] ovr_data, target_n, pc_model;
    int          mem_lat, wait_cnt;
    int          n_checks, n_pass, pops_seen, p0;
    entry_t      exp_q[$];
    logic [6:0]  pat;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return 32'h3C01_0001 + a;
    endfunction

    task automatic count_result(input bit ok, input string name,
                                input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        count_result(act === exp, name, {63'd0, act}, {63'd0, exp});
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        count_result(act === exp, name, {32'd0, act}, {32'd0, exp});
    endtask

    task automatic exp_push(input logic [31:0] pc, input logic [31:0] inst);
        exp_q.push_back(entry_t'({pc, inst}));
    endtask

    // One cycle: apply inputs on the falling edge, answer memory, model the PC register.
    task automatic tick();
        @(negedge clk);
        pc_i             = pc_model;
        ce_i             = ce_n;
        branch_flag_i    = br_n;
        bus.id_ready_i   = rdy_n;
        bus.imem_ack_i   = 1'b0;
        if (stray_ack) begin
            bus.imem_ack_i   = 1'b1;
            bus.imem_rdata_i = 32'h0BAD_0BAD;
        end else if (bus.imem_req_o) begin
            if (wait_cnt >= mem_lat) begin
                bus.imem_ack_i   = 1'b1;
                bus.imem_rdata_i = ovr_en ? ovr_data : inst_of(bus.imem_addr_o);
                wait_cnt         = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        #1;
        if (rst) pc_model = 32'h0;
        else if (br_n) pc_model = target_n;
        else if (ce_n && !bbl_o) pc_model = pc_model + 32'd4;
    endtask

    task automatic do_reset();
        rst = 1'b1; ce_n = 1'b0; br_n = 1'b0; rdy_n = 1'b0;
        stray_ack = 1'b0; ovr_en = 1'b0; mem_lat = 0; pc_model = 32'h0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Monitor: compare every entry decode takes against the expected queue.
    initial begin
        entry_t got;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.id_valid_o && bus.id_ready_i && !branch_flag_i) begin
                pops_seen++;
                got = entry_t'({bus.id_pc_o, bus.id_inst_o});
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_pop: got %h expected no entry", got);
                end else begin
                    count_result(got === exp_q[0], "pop_entry", got, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        n_checks = 0; n_pass = 0; pops_seen = 0;
        rst = 1'b1; pc_i = '0; ce_i = 1'b0; branch_flag_i = 1'b0;
        bus.imem_ack_i = 1'b0; bus.imem_rdata_i = '0; bus.id_ready_i = 1'b0;
        ce_n = 1'b0; br_n = 1'b0; rdy_n = 1'b0; stray_ack = 1'b0; ovr_en = 1'b0;
        ovr_data = '0; target_n = '0; pc_model = '0; mem_lat = 0; wait_cnt = 0;
        #3;
        chk1 ("rst_req",   bus.imem_req_o, 1'b0);
        chk32("rst_addr",  bus.imem_addr_o, 32'h0);
        chk1 ("rst_valid", bus.id_valid_o, 1'b0);
        chk32("rst_pc",    bus.id_pc_o, 32'h0);
        chk32("rst_inst",  bus.id_inst_o, 32'h0);
        chk1 ("rst_bbl",   bbl_o, 1'b0);

        // Test 1: single fetch, ack three cycles after the request.
        do_reset();
        mem_lat = 3; ce_n = 1'b1;
        exp_push(32'h0, 32'h3C01_0001);
        tick(); chk1("t1_bbl_idle", bbl_o, 1'b0);
        tick(); chk1("t1_req", bus.imem_req_o, 1'b1);
                chk32("t1_addr", bus.imem_addr_o, 32'h0);
                chk1("t1_bbl_req", bbl_o, 1'b1);
        tick(); tick();
        ce_n = 1'b0;
        tick(); chk1("t1_valid_before", bus.id_valid_o, 1'b0);
        tick(); chk1("t1_valid", bus.id_valid_o, 1'b1);
                chk32("t1_id_pc", bus.id_pc_o, 32'h0);
                chk32("t1_id_inst", bus.id_inst_o, 32'h3C01_0001);
                chk1("t1_req_done", bus.imem_req_o, 1'b0);
        rdy_n = 1'b1;
        tick(); tick(); chk1("t1_drained", bus.id_valid_o, 1'b0);

        // Test 2: zero-wait memory, one entry every two cycles.
        do_reset();
        mem_lat = 0; rdy_n = 1'b1;
        exp_push(32'h0, 32'h3C01_0001);
        exp_push(32'h4, 32'h3C01_0005);
        exp_push(32'h8, 32'h3C01_0009);
        p0 = pops_seen;
        pat = 7'b1010100;
        for (int i = 0; i < 7; i++) begin
            ce_n = (i < 6);
            tick();
            chk1($sformatf("t2_valid_c%0d", i), bus.id_valid_o, pat[i]);
        end
        tick(); chk32("t2_pops", 32'(pops_seen - p0), 32'd3);
                chk1("t2_req_off", bus.imem_req_o, 1'b0);

        // Test 3: decode stalled, FIFO fills, then drains and fetch resumes at 0x8.
        do_reset();
        mem_lat = 0; ce_n = 1'b1;
        exp_push(32'h0, 32'h3C01_0001);
        exp_push(32'h4, 32'h3C01_0005);
        exp_push(32'h8, 32'h3C01_0009);
        tick(); tick(); tick(); tick();
        for (int i = 0; i < 2; i++) begin
            tick();
            chk1("t3_full_bbl", bbl_o, 1'b1);
            chk1("t3_full_req", bus.imem_req_o, 1'b0);
            chk1("t3_full_valid", bus.id_valid_o, 1'b1);
        end
        p0 = pops_seen;
        rdy_n = 1'b1;
        tick(); chk1("t3_bbl_c6", bbl_o, 1'b1);
        tick(); chk1("t3_bbl_c7", bbl_o, 1'b0);
        ce_n = 1'b0;
        tick(); chk1("t3_resume_req", bus.imem_req_o, 1'b1);
                chk32("t3_resume_addr", bus.imem_addr_o, 32'h8);
                chk1("t3_empty", bus.id_valid_o, 1'b0);
                chk32("t3_pops", 32'(pops_seen - p0), 32'd2);
        tick(); tick(); chk1("t3_drained", bus.id_valid_o, 1'b0);

        // Test 4: branch while reading 0x4; late ack is dropped, fetch moves to 0x100.
        do_reset();
        mem_lat = 0; ce_n = 1'b1; target_n = 32'h100;
        tick(); tick(); tick();
        mem_lat = 2; br_n = 1'b1;
        tick(); chk1("t4_bbl_branch", bbl_o, 1'b0);
        br_n = 1'b0;
        tick(); chk1("t4_flushed", bus.id_valid_o, 1'b0);
                chk1("t4_discard_req", bus.imem_req_o, 1'b1);
                chk1("t4_discard_bbl", bbl_o, 1'b1);
        ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
        tick();
        ovr_en = 1'b0; mem_lat = 0;
        exp_push(32'h100, 32'h3C01_0101);
        tick(); chk1("t4_dropped", bus.id_valid_o, 1'b0);
                chk1("t4_idle_req", bus.imem_req_o, 1'b0);
        ce_n = 1'b0;
        tick(); chk32("t4_target_addr", bus.imem_addr_o, 32'h100);
                chk1("t4_target_req", bus.imem_req_o, 1'b1);
        tick(); chk32("t4_head_pc", bus.id_pc_o, 32'h100);
        rdy_n = 1'b1;
        tick(); tick(); chk1("t4_drained", bus.id_valid_o, 1'b0);

        // Test 5: branch, ack and decode pop on the same edge.
        do_reset();
        mem_lat = 0; ce_n = 1'b1; target_n = 32'h200;
        tick(); tick(); tick();
        br_n = 1'b1; rdy_n = 1'b1;
        tick(); chk1("t5_bbl_branch", bbl_o, 1'b0);
        br_n = 1'b0; rdy_n = 1'b0;
        exp_push(32'h200, 32'h3C01_0201);
        tick(); chk1("t5_empty", bus.id_valid_o, 1'b0);
                chk1("t5_idle_req", bus.imem_req_o, 1'b0);
        ce_n = 1'b0;
        tick(); chk32("t5_target_addr", bus.imem_addr_o, 32'h200);
        rdy_n = 1'b1;
        tick(); tick(); chk1("t5_drained", bus.id_valid_o, 1'b0);

        // Test 6: reset in the middle of a read, stray ack afterwards.
        do_reset();
        mem_lat = 0; ce_n = 1'b1;
        tick(); tick(); tick();
        mem_lat = 5;
        tick(); chk32("t6_addr_before", bus.imem_addr_o, 32'h4);
                chk32("t6_inst_before", bus.id_inst_o, 32'h3C01_0001);
        #2;
        rst = 1'b1;
        #1;
        chk1 ("t6_async_req", bus.imem_req_o, 1'b0);
        chk32("t6_async_addr", bus.imem_addr_o, 32'h0);
        chk1 ("t6_async_valid", bus.id_valid_o, 1'b0);
        chk32("t6_async_pc", bus.id_pc_o, 32'h0);
        chk32("t6_async_inst", bus.id_inst_o, 32'h0);
        chk1 ("t6_async_bbl", bbl_o, 1'b0);
        ce_n = 1'b0;
        tick();
        rst = 1'b0;
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0; ce_n = 1'b1; mem_lat = 0;
        exp_push(32'h0, 32'h3C01_0001);
        tick(); chk1("t6_stray_valid", bus.id_valid_o, 1'b0);
                chk1("t6_stray_req", bus.imem_req_o, 1'b0);
        tick(); chk1("t6_restart_req", bus.imem_req_o, 1'b1);
                chk32("t6_restart_addr", bus.imem_addr_o, 32'h0);
        ce_n = 1'b0; rdy_n = 1'b1;
        tick(); tick(); chk1("t6_drained", bus.id_valid_o, 1'b0);

        tick(); tick();
        chk32("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
